// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S master transmitter.
// Format is Philips I2S unless I2S_TX_LJ_EN is defined (left-justified).
package i2s_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStop
  } i2s_state_e;

  function automatic int unsigned frame_bits(int unsigned slot_bits);
    return 2 * slot_bits;
  endfunction

`ifdef I2S_TX_LJ_EN
  localparam bit LeftJustified = 1'b1;
`else
  localparam bit LeftJustified = 1'b0;
`endif

endpackage

// File: rtl/i2s_sck_gen.sv
// SCK divider: toggles sck every SCK_HALF cycles while run is high and
// flags the cycle before each falling/rising edge.
module i2s_sck_gen #(
  parameter int unsigned SCK_HALF = 2
) (
  input  logic clk_12M,
  input  logic rst,
  input  logic run,
  output logic sck,
  output logic fall,
  output logic rise
);

  localparam int unsigned CW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

  logic [CW-1:0] div_q;
  logic          sck_q;
  logic          wrap;

  assign wrap = (div_q == CW'(SCK_HALF - 1));

  always_ff @(posedge clk_12M or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      sck_q <= 1'b0;
    end else if (!run) begin
      div_q <= '0;
      sck_q <= 1'b0;
    end else if (wrap) begin
      div_q <= '0;
      sck_q <= ~sck_q;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign sck  = sck_q;
  assign fall = wrap && sck_q;
  assign rise = wrap && !sck_q;

endmodule

// File: rtl/i2s_master_tx.sv
// I2S bus-master transmitter: one-deep sample-pair holding register feeding a
// frame shift register. Define I2S_TX_LJ_EN for left-justified output.
module i2s_master_tx
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SLOT_BITS  = 32,
  parameter int unsigned SCK_HALF   = 2
) (
  input  logic                  clk_12M,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_ldata,
  input  logic [DATA_WIDTH-1:0] in_rdata,
  output logic                  sck,
  output logic                  ws,
  output logic                  sda,
  output logic                  frame_start,
  output logic                  underflow
);

  localparam int unsigned FrameBits = frame_bits(SLOT_BITS);
  localparam int unsigned BW        = $clog2(FrameBits);

  i2s_state_e state_q, state_d;

  logic                  run, fall, rise;
  logic [BW-1:0]         b_q, b_d;
  logic                  first_q, first_d;
  logic [FrameBits-1:0]  sr_q, sr_d, frame_word;
  logic [SLOT_BITS-1:0]  lslot, rslot;
  logic                  hold_full_q, hold_full_d, ready_q;
  logic [DATA_WIDTH-1:0] hold_l_q, hold_r_q;
  logic                  ws_q, ws_d, sda_q, sda_d, fs_q, fs_d, uf_q, uf_d;
  logic                  boundary, accept;

  // In STOP, drop run on the rise strobe so sck stays low and the divider clears.
  assign run = (state_q == StRun) || ((state_q == StStop) && !rise);

  i2s_sck_gen #(
    .SCK_HALF(SCK_HALF)
  ) u_sck_gen (
    .clk_12M(clk_12M),
    .rst    (rst),
    .run    (run),
    .sck    (sck),
    .fall   (fall),
    .rise   (rise)
  );

  assign accept   = in_valid && ready_q;
  assign boundary = first_q || (b_q == BW'(FrameBits - 1));

  always_ff @(posedge clk_12M or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en) state_d = StRun;
      StRun:   if (fall && boundary && !en) state_d = StStop;
      StStop:  if (rise) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    lslot = '0;
    rslot = '0;
    if (hold_full_q) begin
      lslot[SLOT_BITS-1 -: DATA_WIDTH] = hold_l_q;
      rslot[SLOT_BITS-1 -: DATA_WIDTH] = hold_r_q;
    end
    frame_word = {lslot, rslot};
    // Philips format delays the data one SCK behind the ws transition.
    if (!LeftJustified) frame_word = frame_word >> 1;
  end

  always_comb begin
    b_d         = b_q;
    first_d     = first_q;
    sr_d        = sr_q;
    ws_d        = ws_q;
    sda_d       = sda_q;
    fs_d        = 1'b0;
    uf_d        = 1'b0;
    hold_full_d = hold_full_q;
    if (state_q == StIdle) begin
      b_d     = '0;
      first_d = en;
      ws_d    = 1'b0;
      sda_d   = 1'b0;
      sr_d    = '0;
    end else if ((state_q == StRun) && fall) begin
      first_d = 1'b0;
      if (boundary) begin
        b_d = '0;
        if (en) begin
          sda_d       = frame_word[FrameBits-1];
          sr_d        = frame_word << 1;
          fs_d        = 1'b1;
          uf_d        = !hold_full_q;
          hold_full_d = 1'b0;
        end else begin
          sda_d = 1'b0;
          sr_d  = '0;
        end
      end else begin
        b_d   = b_q + 1'b1;
        sda_d = sr_q[FrameBits-1];
        sr_d  = sr_q << 1;
      end
      ws_d = (b_d >= BW'(SLOT_BITS));
    end
    if (accept) hold_full_d = 1'b1;
  end

  always_ff @(posedge clk_12M or posedge rst) begin
    if (rst) begin
      b_q         <= '0;
      first_q     <= 1'b0;
      sr_q        <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      ws_q        <= 1'b0;
      sda_q       <= 1'b0;
      fs_q        <= 1'b0;
      uf_q        <= 1'b0;
    end else begin
      b_q         <= b_d;
      first_q     <= first_d;
      sr_q        <= sr_d;
      hold_full_q <= hold_full_d;
      ready_q     <= !hold_full_d;
      ws_q        <= ws_d;
      sda_q       <= sda_d;
      fs_q        <= fs_d;
      uf_q        <= uf_d;
      if (accept) begin
        hold_l_q <= in_ldata;
        hold_r_q <= in_rdata;
      end
    end
  end

  assign in_ready    = ready_q;
  assign ws          = ws_q;
  assign sda         = sda_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;

endmodule

// File: tb/tb_i2s_master_tx.sv
// Bench for i2s_master_tx: timing-arithmetic reference model checked every
// cycle, plus literal frame/timing expectations.
module tb_i2s_master_tx;

  localparam int H    = 2;
  localparam int SLOT = 32;
  localparam int DW   = 16;
  localparam int F    = 2 * SLOT;

`ifdef I2S_TX_LJ_EN
  localparam logic [63:0] Lit1 = 64'hA5C3_0000_7FFF_0000;
  localparam logic [63:0] Lit2 = 64'h8001_0000_0001_0000;
`else
  localparam logic [63:0] Lit1 = 64'h52E1_8000_3FFF_8000;
  localparam logic [63:0] Lit2 = 64'h4000_8000_0000_8000;
`endif

  logic clk_12M = 1'b0;
  logic rst, en, in_valid, in_ready;
  logic [DW-1:0] in_ldata, in_rdata;
  logic sck, ws, sda, frame_start, underflow;

  i2s_master_tx #(
    .DATA_WIDTH(DW),
    .SLOT_BITS (SLOT),
    .SCK_HALF  (H)
  ) dut (
    .clk_12M    (clk_12M),
    .rst        (rst),
    .en         (en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ldata   (in_ldata),
    .in_rdata   (in_rdata),
    .sck        (sck),
    .ws         (ws),
    .sda        (sda),
    .frame_start(frame_start),
    .underflow  (underflow)
  );

  always #5 clk_12M = ~clk_12M;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
    end
  endtask

  // Bit carried on sda at bit position b of a frame holding (l, r).
  function automatic logic bit_at(input int b, input logic [DW-1:0] l, input logic [DW-1:0] r);
    int p, d;
    logic [DW-1:0] s;
    p = b % SLOT;
    s = (b < SLOT) ? l : r;
`ifdef I2S_TX_LJ_EN
    d = p;
`else
    d = p - 1;
`endif
    if (d >= 0 && d < DW) return s[DW-1-d];
    return 1'b0;
  endfunction

  // Reference model: mode 0 idle, 1 run (t = cycles since leaving idle), 2 stop.
  int m_mode, m_t, m_stop;
  logic m_full, m_ready;
  logic [DW-1:0] m_hl, m_hr, m_fl, m_fr;
  logic e_sck, e_ws, e_sda, e_fs, e_uf;

  always @(posedge clk_12M or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_t = 0; m_stop = 0;
      m_full = 1'b0; m_ready = 1'b1;
      m_hl = '0; m_hr = '0; m_fl = '0; m_fr = '0;
      e_sck = 1'b0; e_ws = 1'b0; e_sda = 1'b0; e_fs = 1'b0; e_uf = 1'b0;
    end else begin
      logic acc;
      int n, b;
      acc  = in_valid && m_ready;
      e_fs = 1'b0;
      e_uf = 1'b0;
      case (m_mode)
        0: if (en) begin m_mode = 1; m_t = 0; end
        1: begin
          m_t++;
          e_sck = ((m_t / H) % 2) == 1;
          if (m_t % (2 * H) == 0) begin
            n = m_t / (2 * H);
            b = (n - 1) % F;
            if (b == 0) begin
              if (!en) begin
                m_mode = 2; m_stop = 0; e_ws = 1'b0; e_sda = 1'b0;
              end else begin
                e_fs = 1'b1;
                e_uf = !m_full;
                m_fl = m_full ? m_hl : '0;
                m_fr = m_full ? m_hr : '0;
                m_full = 1'b0;
              end
            end
            if (m_mode == 1) begin
              e_ws  = (b >= SLOT);
              e_sda = bit_at(b, m_fl, m_fr);
            end
          end
        end
        default: begin
          m_stop++;
          if (m_stop == H) m_mode = 0;
        end
      endcase
      if (acc) begin
        m_hl = in_ldata; m_hr = in_rdata; m_full = 1'b1;
      end
      m_ready = !m_full;
    end
  end

  int cyc = 0;
  always @(posedge clk_12M) cyc++;

  // Per-cycle compare plus frame capture on sck rising edges.
  logic chk_on = 1'b0;
  logic prev_sck = 1'b0;
  logic [63:0] cap, last_frame;
  int cap_idx = 0;
  int last_rise = 0, sck_per = 0;
  int uf_cnt = 0, uf_last = 0, uf_prev = 0;
  int acc_last = 0, acc_prev = 0;

  always @(negedge clk_12M) begin
    if (!rst && chk_on) begin
      chk("sck", 64'(sck), 64'(e_sck));
      chk("ws", 64'(ws), 64'(e_ws));
      chk("sda", 64'(sda), 64'(e_sda));
      chk("frame_start", 64'(frame_start), 64'(e_fs));
      chk("underflow", 64'(underflow), 64'(e_uf));
      chk("in_ready", 64'(in_ready), 64'(m_ready));
    end
    if (!rst) begin
      if (frame_start) begin
        if (cap_idx == 64) last_frame = cap;
        cap_idx = 0;
        cap = '0;
      end
      if (sck && !prev_sck) begin
        if (cap_idx < 64) begin
          cap[63-cap_idx] = sda;
          cap_idx++;
        end
        sck_per = cyc - last_rise;
        last_rise = cyc;
      end
      if (underflow) begin
        uf_cnt++; uf_prev = uf_last; uf_last = cyc;
      end
      if (in_valid && in_ready) begin
        acc_prev = acc_last; acc_last = cyc;
      end
    end
    prev_sck = sck;
  end

  task automatic wait_fs();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_12M);
      #1;
      if (frame_start) return;
    end
    chk("frame_start_timeout", 64'd1, 64'd0);
  endtask

  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
    @(negedge clk_12M);
    in_valid = 1'b1; in_ldata = l; in_rdata = r;
    for (int i = 0; i < 1000; i++) begin
      if (in_ready) begin
        @(negedge clk_12M);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk_12M);
    end
    chk("send_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
  endtask

  initial begin
    int snap, sck_hi, rdy_hi;
    logic pend;
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_ldata = '0; in_rdata = '0;
    repeat (3) @(negedge clk_12M);
    #1;
    chk("rst_sck", 64'(sck), 64'd0);
    chk("rst_ws", 64'(ws), 64'd0);
    chk("rst_sda", 64'(sda), 64'd0);
    chk("rst_fs", 64'(frame_start), 64'd0);
    chk("rst_uf", 64'(underflow), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk_12M);
    rst = 1'b0; chk_on = 1'b1;
    repeat (5) @(negedge clk_12M);

    // Free-running with no data: every frame underflows.
    en = 1'b1;
    repeat (600) @(negedge clk_12M);
    #1;
    chk("sck_period", 64'(sck_per), 64'd4);
    chk("uf_interval", 64'(uf_last - uf_prev), 64'd256);
    chk("uf_count", 64'(uf_cnt), 64'd3);

    // Two directed pairs, captured bit-by-bit on sck rises.
    send(16'hA5C3, 16'h7FFF);
    wait_fs();
    chk("load1_no_uf", 64'(underflow), 64'd0);
    send(16'h8001, 16'h0001);
    wait_fs();
    chk("frame1_bits", last_frame, Lit1);
    chk("load2_no_uf", 64'(underflow), 64'd0);
    wait_fs();
    chk("frame2_bits", last_frame, Lit2);

    // Continuous valid: one pair per frame, never an underflow.
    snap = uf_cnt;
    in_valid = 1'b1; in_ldata = 16'h1111; in_rdata = 16'h2222;
    pend = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk_12M);
      if (pend) begin
        in_ldata = in_ldata + 16'd3;
        in_rdata = in_rdata ^ 16'h1234;
      end
      pend = in_ready;
    end
    @(negedge clk_12M);
    in_valid = 1'b0;
    #1;
    chk("stream_no_uf", 64'(uf_cnt - snap), 64'd0);
    chk("stream_acc_interval", 64'(acc_last - acc_prev), 64'd256);

    // Drop en at b=10 with a pair pending: frame completes, pair stays held.
    wait_fs();
    send(16'h0F0F, 16'hF0F0);
    repeat (37) @(negedge clk_12M);
    en = 1'b0;
    repeat (230) @(negedge clk_12M);
    sck_hi = 0; rdy_hi = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_12M);
      #1;
      if (sck) sck_hi++;
      if (in_ready) rdy_hi++;
    end
    chk("stop_sck_low", 64'(sck_hi), 64'd0);
    chk("stop_pair_kept", 64'(rdy_hi), 64'd0);
    chk("stop_ws", 64'(ws), 64'd0);

    // Restart, then reset at b=40 with a pair pending.
    en = 1'b1;
    wait_fs();
    send(16'h1234, 16'h5678);
    repeat (157) @(negedge clk_12M);
    rst = 1'b1;
    #1;
    chk("midrst_sck", 64'(sck), 64'd0);
    chk("midrst_ws", 64'(ws), 64'd0);
    chk("midrst_sda", 64'(sda), 64'd0);
    chk("midrst_fs", 64'(frame_start), 64'd0);
    chk("midrst_uf", 64'(underflow), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    repeat (3) @(negedge clk_12M);
    rst = 1'b0;
    wait_fs();
    chk("post_rst_uf", 64'(underflow), 64'd1);
    repeat (10) @(negedge clk_12M);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_master_tx.md
# i2s_master_tx

I2S bus-master transmitter: derives SCK/WS from `clk_12M` and serializes 16-bit stereo sample pairs onto SDA for a slave-mode DAC (ES8156 in slave mode, or an external I2S sink). It is the driving end of the same serial link that `pgr_i2s_rx` and `pgr_i2s_tx` consume as slaves. Samples enter through a valid/ready handshake from the audio datapath, for example the loop block or a DSP stage. A one-deep holding register decouples upstream timing from frame timing.

## Interface
- `DATA_WIDTH`, 16: sample width per channel; must be ≤ `SLOT_BITS`.
- `SLOT_BITS`, 32: SCK periods per channel slot; frame = 2×`SLOT_BITS`.
- `SCK_HALF`, 2: `clk_12M` cycles per SCK half-period; ≥1. Defaults give 3.072 MHz SCK, 48 kHz WS.
- `clk_12M`  in  1  sole clock, 12.288 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  run enable; sampled at frame boundaries only.
- `in_valid`  in  1  sample pair offered.
- `in_ready`  out  1  holding register empty.
- `in_ldata`  in  DATA_WIDTH  left sample, two's complement.
- `in_rdata`  in  DATA_WIDTH  right sample.
- `sck`  out  1  I2S bit clock.
- `ws`  out  1  I2S word select: 0 = left, 1 = right.
- `sda`  out  1  serial data, MSB first.
- `frame_start`  out  1  one-cycle pulse at each frame load.
- `underflow`  out  1  one-cycle pulse when a frame loads with the holding register empty.

## Operation
- Reset values:
  - `sck`, `ws`, `sda`, `frame_start`, `underflow` = 0.
  - Holding register empty, so `in_ready` = 1.
  - Divider and bit counter = 0.
  - State = IDLE.
- Handshake:
  - A transfer occurs on a cycle where `in_valid` && `in_ready`. Both samples are captured and `hold_full` is set.
  - `in_ready` = !`hold_full`, driven from a register.
  - Upstream holds data stable while `in_valid` && !`in_ready`.
- Divider:
  - `div_cnt` counts 0..`SCK_HALF`-1.
  - On wrap, `sck` toggles.
  - A fall event is a wrap while `sck` = 1.
- Bit counter `b`:
  - Range 0..2×`SLOT_BITS`-1, advanced on each fall event.
  - Wraps from the last value to 0. That wrap is the frame boundary.
- Slot mapping (Philips I2S):
  - `ws` = 1 for b in `SLOT_BITS`..2×`SLOT_BITS`-1, else 0.
  - Left MSB at b = 1; right MSB at b = `SLOT_BITS`+1.
  - Bits beyond `DATA_WIDTH` in each slot are driven 0.
  - b = 0 and b = `SLOT_BITS` carry 0.
  - `ws` and `sda` change only on fall events.
- Frame load, at a frame boundary in RUN:
  - If `hold_full`: copy the pair to the shift registers, clear `hold_full`, pulse `frame_start`.
  - Else: load zeros, pulse both `frame_start` and `underflow`.
- States:
  - IDLE: `sck` = 0, `ws` = 0, `sda` = 0, counters held at 0. Go to RUN when `en` = 1. The first fall event is then a frame load, and b stays 0 for that load.
  - RUN: normal operation. At a frame boundary with `en` = 0, go to STOP.
  - STOP: finish the remaining SCK low half-period, then go to IDLE. Never truncate a frame.
- Simultaneous events: a frame load and a handshake acceptance cannot coincide. `hold_full` = 1 blocks acceptance; the freed slot is visible as `in_ready` = 1 on the next cycle.
- Reset mid-frame: all outputs return to reset values immediately. A pending pair is discarded.
- `en` toggled mid-frame has no effect until the next boundary.

## Timing
- SCK period = 2×`SCK_HALF` `clk_12M` cycles, 50 % duty. The first rising edge comes `SCK_HALF` cycles after leaving IDLE.
- `sda`/`ws` update in the same cycle `sck` falls, so they are stable across the rising edge where the sink samples.
- Latency: a pair accepted before boundary N has its left MSB on `sda` one SCK period after boundary N. Its right MSB follows `SLOT_BITS` SCK periods later.
- `frame_start` and `underflow` assert in the cycle after the boundary fall event.
- Throughput: one pair per 2×`SLOT_BITS`×2×`SCK_HALF` cycles (256 at defaults).

## Configuration
- `I2S_TX_LJ_EN` defined: left-justified format. MSB at b = 0 and b = `SLOT_BITS`, with no one-bit delay. `ws` is unchanged.
- Undefined: Philips I2S as above.

## Structure
- `i2s_pkg`: state enum (IDLE/RUN/STOP), frame-length helper constant, format-select constant derived from the macro.
- Sub-module `i2s_sck_gen`: divider, `sck` register, fall-event and rise-event strobes. It has `clk_12M`/`rst`/`run` in and `sck`/`fall`/`rise` out.
- Top holds the handshake register, bit counter, shift registers and FSM.

## Test plan
- Reset, then `en` = 1, no data → SCK period 4 cycles; `ws` low 32 SCK then high 32; `sda` = 0; `underflow` pulses each 256 cycles.
- Send L = 16'hA5C3, R = 16'h7FFF → `sda` (sampled on SCK rising edges from b = 1) reads 1010_0101_1100_0011; right slot reads 0111_1111_1111_1111; remaining slot bits 0; no `underflow` on that frame.
- Hold `in_valid` = 1 continuously → `in_ready` accepts one pair per frame; a stable `in_ready` low for ≈256 cycles between transfers; zero `underflow` pulses.
- Drop `en` at b = 10 → current frame completes; `sck` idles low after the boundary; the next pair is not consumed.
- Assert `rst` at b = 40 with a pair pending → all outputs 0 in the same cycle; `in_ready` = 1; after release and `en` = 1, the first frame underflows.
- Rebuild with `I2S_TX_LJ_EN`, L = 16'h8001 → `sda` = 1 at b = 0 and 1 at b = 15.
